// File: rtl/scan_pkg.sv
// Shared types for the scan load/capture/unload controller.
package scan_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCapture,
    StUnload,
    StFinish
  } scan_state_e;

  function automatic int unsigned cnt_width(input int unsigned chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Pattern/response and scan-pin bundle between test logic, controller and chain.
interface scan_chain_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 8
);
  logic                 START;
  logic [CHAIN_LEN-1:0] PAT_IN;
  logic                 SO;
  logic                 SE;
  logic                 SI;
  logic [CHAIN_LEN-1:0] CAP_OUT;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    output START, PAT_IN, SO,
    input  SE, SI, CAP_OUT, BUSY, DONE
  );

  modport slave (
    input  START, PAT_IN, SO,
    output SE, SI, CAP_OUT, BUSY, DONE
  );
endinterface

// File: rtl/scan_shift_reg.sv
// Shift register with parallel load, left shift (MSB out) and right shift (serial in at MSB).
module scan_shift_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             shl_i,
  input  logic             shr_i,
  input  logic             ser_i,
  output logic [Width-1:0] q_o,
  output logic             msb_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_val_i;
    end else if (shl_i) begin
      q_q <= {q_q[Width-2:0], 1'b0};
    end else if (shr_i) begin
      q_q <= {ser_i, q_q[Width-1:1]};
    end
  end

  assign q_o   = q_q;
  assign msb_o = q_q[Width-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan controller: serial load of a pattern, one capture cycle, serial unload of the response.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 8
) (
  input logic              CK,
  input logic              RST,
  scan_chain_ctrl_if.slave bus
);

  localparam int unsigned CntW = cnt_width(CHAIN_LEN);

  scan_state_e          state_q;
  logic [CntW-1:0]      cnt_q;
  logic                 cnt_last;
  logic                 load_msb;
  logic [CHAIN_LEN-1:0] unload_q;
  logic [CHAIN_LEN-1:0] unused_load_q;
  logic                 unused_unload_msb;

  assign cnt_last = (cnt_q == CntW'(CHAIN_LEN - 1));

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (bus.START) state_q <= StShift;
        end
        StShift: begin
          if (cnt_last) begin
            state_q <= StCapture;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StCapture: begin
          state_q <= StUnload;
          cnt_q   <= '0;
        end
        StUnload: begin
          if (cnt_last) begin
            state_q <= StFinish;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StFinish: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  scan_shift_reg #(
    .Width(CHAIN_LEN)
  ) u_load_reg (
    .clk_i     (CK),
    .clr_i     (RST),
    .load_i    ((state_q == StIdle) && bus.START),
    .load_val_i(bus.PAT_IN),
    .shl_i     (state_q == StShift),
    .shr_i     (1'b0),
    .ser_i     (1'b0),
    .q_o       (unused_load_q),
    .msb_o     (load_msb)
  );

  scan_shift_reg #(
    .Width(CHAIN_LEN)
  ) u_unload_reg (
    .clk_i     (CK),
    .clr_i     (RST),
    .load_i    (1'b0),
    .load_val_i('0),
    .shl_i     (1'b0),
    .shr_i     (state_q == StUnload),
    .ser_i     (bus.SO),
    .q_o       (unload_q),
    .msb_o     (unused_unload_msb)
  );

  // The tail flop comes out first and ends up at bit 0 of the unload register, so the
  // register is bit-reversed relative to chain position.
  always_comb begin
    bus.CAP_OUT = '0;
    for (int k = 0; k < CHAIN_LEN; k++) begin
      bus.CAP_OUT[k] = unload_q[CHAIN_LEN-1-k];
    end
  end

  always_comb begin
    bus.SE   = (state_q == StShift) || (state_q == StUnload);
    bus.SI   = (state_q == StShift) ? load_msb : 1'b0;
    bus.BUSY = (state_q != StIdle);
    bus.DONE = (state_q == StFinish);
  end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Scan load/capture/unload controller sitting directly upstream of a chain of SDFFS_X2 scan flops. It drives the chain's SE and SI pins and samples the chain-tail SO, which is the tail flop's Q. One operation proceeds in three phases: it serially loads a parallel test pattern, pulses a one-cycle functional capture, then serially unloads the captured response into a parallel register. The block is used by scan-test benches and by the on-chip test access logic that exercises standard-cell scan chains.

## Interface
- CHAIN_LEN, default 8: number of scan flops in the chain; must be ≥ 2.
- CK  in  1: clock; all state changes on the rising edge.
- RST  in  1: reset, synchronous, active-high.
- START  in  1: request one load/capture/unload operation; sampled only in IDLE.
- PAT_IN  in  CHAIN_LEN: pattern to load; flop k of the chain (k=0 at SI head) receives PAT_IN[k]; latched on the START edge.
- SO  in  1: Q of chain tail flop (index CHAIN_LEN-1).
- SE  out  1: scan enable to every chain flop.
- SI  out  1: serial data into chain head flop.
- CAP_OUT  out  CHAIN_LEN: captured response; CAP_OUT[k] = value flop k held after capture.
- BUSY  out  1: high in every state except IDLE.
- DONE  out  1: one-cycle pulse; CAP_OUT valid from this cycle until the next accepted START.

## Operation
- States: IDLE, SHIFT, CAPTURE, UNLOAD, FINISH.
- IDLE: SE=0, SI=0. If START=1 at the edge, latch PAT_IN into the load register, clear the bit counter, and go to SHIFT.
- SHIFT: SE=1, SI = MSB of the load register. The load register shifts left once per edge. Bits are sent in order PAT_IN[CHAIN_LEN-1] first and PAT_IN[0] last. After CHAIN_LEN edges, go to CAPTURE.
- CAPTURE: SE=0 and SI=0 for exactly one edge, so the chain captures its functional D inputs. Then go to UNLOAD.
- UNLOAD: SE=1, SI=0. On unload edge i (i = 0..CHAIN_LEN-1), SO is sampled into CAP_OUT[CHAIN_LEN-1-i]; this is a right-shift-in of SO at the MSB. After CHAIN_LEN edges, go to FINISH.
- FINISH: SE=0, DONE=1, BUSY=1 for one cycle, then IDLE.
- START outside IDLE is ignored; it is not queued.
- Counter width is $clog2(CHAIN_LEN+1). The counter terminates at CHAIN_LEN-1 and clears on every phase change; it has no wrap-around beyond that.
- Reset, including mid-operation, forces: state=IDLE, SE=0, SI=0, BUSY=0, DONE=0, CAP_OUT=0, load register=0, counter=0. The chain's own contents are not touched, and a partial load is abandoned.
- The block never drives the flops' SN; any set activity on the chain is outside this block.

## Timing
- SE, SI, BUSY and DONE are decoded from registered state and shift-register MSB only; there is no combinational path from any input.
- START edge = edge 0. Edges 1..CHAIN_LEN shift in. Edge CHAIN_LEN+1 captures. Edges CHAIN_LEN+2..2·CHAIN_LEN+1 unload.
- DONE is high in the cycle after edge 2·CHAIN_LEN+1, and the block is back in IDLE after edge 2·CHAIN_LEN+2.
- With START held high, an operation begins every 2·CHAIN_LEN+3 edges: 19 for CHAIN_LEN=8.
- SO is sampled on the same edge that shifts the chain, so the controller sees the pre-edge tail value. The first unload sample is the captured tail bit.

## Structure
- Package scan_pkg: the state enum (IDLE, SHIFT, CAPTURE, UNLOAD, FINISH) and a function computing the counter width from CHAIN_LEN.
- One sub-module, scan_shift_reg: parameterised width, with parallel load, serial MSB out, serial MSB in and synchronous clear. Instantiated twice, once for load and once for unload.
- The top level holds only the FSM, the counter and the output decode.

## Test plan
The bench uses CHAIN_LEN=8 with eight SDFFS_X2 cells chained Q→SI, SN=1 unless stated, and a cycle counter referenced to the START edge.
- D of each flop tied to its own Q, PAT_IN=8'hA5 → CAP_OUT=8'hA5; DONE high only in the cycle after edge 17; BUSY high from edge 0 through that cycle.
- Same hold wiring, PAT_IN=8'h01 → SI is 0 for the first seven SHIFT cycles and 1 on the eighth; CAP_OUT=8'h01; this checks bit order.
- D inputs tied to constant 8'h3C, PAT_IN=8'hFF → CAP_OUT=8'h3C; SE=0 for exactly one edge, edge 9.
- START held high for 40 cycles → DONE pulses after edges 17 and 36; START pulses mid-operation create no extra operation.
- RST asserted at edge 4 of SHIFT → the next cycle has SE=0, SI=0, BUSY=0, CAP_OUT=0; a following START with PAT_IN=8'h5A and hold wiring → CAP_OUT=8'h5A.
- SN driven low on all flops across the capture edge only, then high → CAP_OUT=8'hFF.
